// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader
package imem_loader_pkg;
   localparam int ADDR_W_DEF  = 8;
   localparam int INSTR_W_DEF = 9;
   localparam int HI_DATA_BIT = 0;
   typedef enum logic [2:0] {S_IDLE, S_COUNT, S_LO, S_HI, S_CSUM, S_RUN, S_ERROR} state_e;
endpackage

// File: rtl/imem_array.sv
// imem_array: instruction storage, one synchronous write port, one asynchronous read port, no reset
module imem_array #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 9
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [INSTR_W-1:0] rdata
);
   logic [INSTR_W-1:0] mem [2**ADDR_W];
   // write the word on the accepting edge; contents persist across loads and resets
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   assign rdata = mem[raddr];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-serial checksummed program loader feeding the core's instruction memory
module imem_loader import imem_loader_pkg::*; #(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_start,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   input  logic [ADDR_W-1:0]  instruction_address,
   output logic [INSTR_W-1:0] instruction,
   output logic               cpu_run,
   output logic               load_error,
   output logic [ADDR_W:0]    words_loaded
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] n_q, n_d, wr_ptr_q, wr_ptr_d;
   logic [7:0]        chk_q, chk_d, lo_q, lo_d;
   logic [ADDR_W:0]   words_q, words_d;
   logic              accept, last, we;
   // load_start wins over a simultaneous byte, so that byte is never consumed
   assign accept = rx_valid && rx_ready && !load_start;
   // a count byte of zero stands for a full 2^ADDR_W word load
   assign last   = (words_q + 1'b1) == {(n_q == '0), n_q};
   assign we     = accept && (state_q == S_HI);
   // sequence the stream: count, lo/hi pairs, checksum
   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      chk_d    = chk_q;
      lo_d     = lo_q;
      wr_ptr_d = wr_ptr_q;
      words_d  = words_q;
      if (load_start) state_d = S_COUNT;
      else if (accept) begin
         case (state_q)
            S_COUNT: begin
               state_d  = S_LO;
               n_d      = ADDR_W'(rx_data);
               chk_d    = rx_data;
               wr_ptr_d = '0;
               words_d  = '0;
            end
            S_LO: begin
               state_d = S_HI;
               lo_d    = rx_data;
               chk_d   = chk_q ^ rx_data;
            end
            S_HI: begin
               state_d  = last ? S_CSUM : S_LO;
               wr_ptr_d = wr_ptr_q + 1'b1;
               words_d  = words_q + 1'b1;
               chk_d    = chk_q ^ rx_data;
            end
            S_CSUM:  state_d = (rx_data == chk_q) ? S_RUN : S_ERROR;
            default: ;
         endcase
      end
   end
   // state register with active-low synchronous reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         n_q      <= '0;
         chk_q    <= '0;
         lo_q     <= '0;
         wr_ptr_q <= '0;
         words_q  <= '0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         chk_q    <= chk_d;
         lo_q     <= lo_d;
         wr_ptr_q <= wr_ptr_d;
         words_q  <= words_d;
      end
   end
   assign rx_ready     = state_q inside {S_COUNT, S_LO, S_HI, S_CSUM};
   assign cpu_run      = state_q == S_RUN;
   assign load_error   = state_q == S_ERROR;
   assign words_loaded = words_q;
   imem_array #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (wr_ptr_q),
      .wdata ({rx_data[HI_DATA_BIT], lo_q}),
      .raddr (instruction_address),
      .rdata (instruction)
   );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a stream-level model
module tb_imem_loader;
   logic       clk = 0, reset = 0, load_start = 0, rx_valid = 0;
   logic [7:0] rx_data = 0, instruction_address = 0;
   logic       rx_ready, cpu_run, load_error;
   logic [8:0] instruction, words_loaded;
   int         tests = 0, fails = 0;
   logic [8:0] ref_mem [256];
   bit         ref_known [256];
   logic [7:0] bq [$];
   int         exp_words;
   bit         exp_run;

   imem_loader dut (
      .clk                 (clk),
      .reset               (reset),
      .load_start          (load_start),
      .rx_data             (rx_data),
      .rx_valid            (rx_valid),
      .rx_ready            (rx_ready),
      .instruction_address (instruction_address),
      .instruction         (instruction),
      .cpu_run             (cpu_run),
      .load_error          (load_error),
      .words_loaded        (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      load_start = 1;
      rx_valid = 0;
      tick;
      load_start = 0;
   endtask

   task automatic stream;
      for (int i = 0; i < bq.size(); i++) begin
         while ($urandom_range(3) == 0) begin
            rx_valid = 0;
            rx_data = 8'($urandom);
            tick;
         end
         rx_valid = 1;
         rx_data = bq[i];
         tests++;
         if (rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL stream_ready byte %0d: rx_ready=%b expected 1", i, rx_ready);
         end
         tick;
      end
      rx_valid = 0;
   endtask

   task automatic build_load(input int n, input bit pattern, input bit corrupt);
      int cnt;
      logic [7:0] chk, lo, hi;
      bq.delete();
      cnt = (n == 0) ? 256 : n;
      bq.push_back(8'(n));
      chk = 8'(n);
      for (int k = 0; k < cnt; k++) begin
         lo = pattern ? 8'(k) : 8'($urandom);
         hi = pattern ? 8'(k & 1) : 8'($urandom);
         bq.push_back(lo);
         bq.push_back(hi);
         chk = chk ^ lo ^ hi;
         ref_mem[k] = {hi[0], lo};
         ref_known[k] = 1;
      end
      bq.push_back(corrupt ? chk ^ 8'($urandom_range(1, 255)) : chk);
      exp_words = cnt;
      exp_run = !corrupt;
   endtask

   task automatic check_result(input string name);
      tests++;
      if (cpu_run !== exp_run || load_error !== !exp_run) begin
         fails++;
         $display("FAIL %s status: cpu_run=%b load_error=%b expected %b %b", name, cpu_run, load_error, exp_run, !exp_run);
      end
      tests++;
      if (words_loaded !== 9'(exp_words)) begin
         fails++;
         $display("FAIL %s words_loaded: got %0d expected %0d", name, words_loaded, exp_words);
      end
   endtask

   task automatic check_mem(input string name);
      int bad = -1;
      logic [8:0] act = 0;
      for (int a = 0; a < 256; a++) begin
         if (ref_known[a]) begin
            instruction_address = 8'(a);
            #1;
            if (instruction !== ref_mem[a] && bad < 0) begin
               bad = a;
               act = instruction;
            end
         end
      end
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s mem[%0d]: instruction=%h expected %h", name, bad, act, ref_mem[bad]);
      end
   endtask

   task automatic check_idle(input string name);
      tests++;
      if (rx_ready !== 0 || cpu_run !== 0 || load_error !== 0 || words_loaded !== 0) begin
         fails++;
         $display("FAIL %s: rdy=%b run=%b err=%b words=%0d expected 0 0 0 0", name, rx_ready, cpu_run, load_error, words_loaded);
      end
   endtask

   task automatic test_reset;
      reset = 0;
      rx_valid = 1;
      rx_data = 8'hA5;
      tick;
      tick;
      check_idle("reset");
      reset = 1;
      for (int i = 0; i < 10; i++) begin
         tick;
         check_idle("idle_valid");
      end
      rx_valid = 0;
   endtask

   task automatic test_directed;
      pulse_start;
      bq = {8'h02, 8'h34, 8'h01, 8'h7F, 8'h00, 8'h48};
      stream;
      ref_mem[0] = 9'h134; ref_known[0] = 1;
      ref_mem[1] = 9'h07F; ref_known[1] = 1;
      exp_words = 2;
      exp_run = 1;
      check_result("directed");
      instruction_address = 8'd1;
      #1;
      tests++;
      if (instruction !== 9'h07F) begin
         fails++;
         $display("FAIL directed_read1: instruction=%h expected 07f", instruction);
      end
      instruction_address = 8'd0;
      #1;
      tests++;
      if (instruction !== 9'h134) begin
         fails++;
         $display("FAIL directed_read0: instruction=%h expected 134", instruction);
      end
   endtask

   task automatic test_bad_csum;
      pulse_start;
      bq = {8'h02, 8'h34, 8'h01, 8'h7F, 8'h00, 8'h49};
      stream;
      exp_words = 2;
      exp_run = 0;
      check_result("bad_csum");
      check_mem("bad_csum");
   endtask

   task automatic test_full;
      pulse_start;
      build_load(0, 1, 0);
      stream;
      check_result("full");
      instruction_address = 8'hFF;
      #1;
      tests++;
      if (instruction !== 9'h1FF) begin
         fails++;
         $display("FAIL full_read255: instruction=%h expected 1ff", instruction);
      end
      check_mem("full");
   endtask

   task automatic test_abort;
      pulse_start;
      bq = {8'h03, 8'h11, 8'h01, 8'h22};
      stream;
      ref_mem[0] = 9'h111;
      rx_valid = 1;
      rx_data = 8'h01;
      load_start = 1;
      tick;
      load_start = 0;
      rx_valid = 0;
      tests++;
      if (rx_ready !== 1 || cpu_run !== 0 || words_loaded !== 9'd1) begin
         fails++;
         $display("FAIL abort_state: rdy=%b run=%b words=%0d expected 1 0 1", rx_ready, cpu_run, words_loaded);
      end
      check_mem("abort_nowrite");
      build_load(1, 0, 0);
      stream;
      check_result("abort_reload");
      check_mem("abort_reload");
   endtask

   task automatic test_random_loads;
      for (int r = 0; r < 6; r++) begin
         pulse_start;
         build_load($urandom_range(1, 24), 0, $urandom_range(0, 2) == 0);
         stream;
         check_result("random");
         check_mem("random");
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] lo, hi;
      pulse_start;
      build_load(3, 0, 0);
      stream;
      check_result("pre_reset_run");
      reset = 0;
      rx_valid = 1'($urandom);
      rx_data = 8'($urandom);
      tick;
      check_idle("reset_in_run");
      reset = 1;
      for (int i = 0; i < 4; i++) begin
         rx_valid = 1'($urandom);
         rx_data = 8'($urandom);
         tick;
      end
      check_idle("after_reset_run");
      check_mem("reset_in_run");
      rx_valid = 0;
      pulse_start;
      lo = 8'($urandom);
      hi = 8'($urandom);
      bq = {8'h05, lo, hi};
      stream;
      ref_mem[0] = {hi[0], lo};
      reset = 0;
      rx_valid = 1'($urandom);
      rx_data = 8'($urandom);
      tick;
      check_idle("reset_in_lo");
      reset = 1;
      rx_valid = 0;
      check_mem("reset_in_lo");
   endtask

   initial begin
      test_reset;
      test_directed;
      test_bad_csum;
      test_full;
      test_abort;
      test_random_loads;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction memory with a byte-serial program loader. It sits directly upstream of the CPU core and drives the core's 9-bit `instruction` input from the core's 8-bit `instruction_address`. Before execution, it accepts a length-prefixed, checksummed program over a valid/ready byte stream. It holds the core stopped until a load completes with a matching checksum.

## Interface
- `ADDR_W`, 8: instruction address width; memory depth is 2^ADDR_W.
- `INSTR_W`, 9: instruction width; must be 9 (two-byte packing below).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clk`.
- `load_start`  in  1  single-cycle pulse that begins or restarts a load from any state.
- `rx_data`  in  8  incoming program byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader will accept a byte this cycle.
- `instruction_address`  in  ADDR_W  fetch address from the core's program counter.
- `instruction`  out  INSTR_W  memory word at `instruction_address`, combinational (asynchronous) read.
- `cpu_run`  out  1  high only in RUN; top level gates the core's reset with it.
- `load_error`  out  1  high only in ERROR.
- `words_loaded`  out  ADDR_W+1  instructions written in the current or last load.

## Operation
- A byte is accepted on a cycle where `rx_valid && rx_ready`. There is no other transfer condition.
- Stream format:
  - COUNT byte N; N=0 means 2^ADDR_W instructions.
  - N pairs of bytes: LO = `instr[7:0]`, then HI, whose bit 0 = `instr[8]`. HI[7:1] are ignored for data but included in the checksum.
  - One CSUM byte. The load is good when CSUM equals the XOR of the COUNT byte and every LO/HI byte.
- State machine:
  - IDLE: `rx_ready`=0. `load_start` → COUNT.
  - COUNT: `rx_ready`=1. On accept: latch N, set chk=byte, set wr_ptr=0, set `words_loaded`=0 → LO.
  - LO: `rx_ready`=1. On accept: hold byte in lo_reg, chk^=byte → HI.
  - HI: `rx_ready`=1. On accept: write {byte[0], lo_reg} to mem[wr_ptr], wr_ptr+1, `words_loaded`+1, chk^=byte. If `words_loaded`+1 == N (or == 2^ADDR_W when N=0) → CSUM, else → LO.
  - CSUM: `rx_ready`=1. On accept: byte==chk → RUN, else → ERROR.
  - RUN: `rx_ready`=0, `cpu_run`=1.
  - ERROR: `rx_ready`=0, `load_error`=1.
- `load_start` in any state, including mid-load, RUN or ERROR, → COUNT next cycle. It has priority over a simultaneous byte accept; that byte is not consumed (`rx_ready` drops to 1-in-COUNT only from the next cycle).
- wr_ptr wraps naturally at 2^ADDR_W; only the N=0 full load reaches it.
- The memory array is not reset. Words beyond N keep their previous contents. After an aborted or failed load, partially written words remain.
- `instruction` always reflects mem[`instruction_address`], including during load. The core is held by `cpu_run`=0 regardless.

## Timing
- Reset values: state IDLE, `rx_ready`=0, `cpu_run`=0, `load_error`=0, `words_loaded`=0, wr_ptr=0, chk=0, lo_reg=0.
- Reset has priority over `load_start` and accept.
- Throughput: one byte per cycle. A load of N words takes 2N+2 accepted bytes.
- A write lands on the edge that accepts HI. A read of that address returns the new word from the following cycle.
- `cpu_run` rises on the cycle after the matching CSUM is accepted. It falls on the cycle after `load_start` or reset.
- `rx_ready` is a function of state only, not of `rx_valid`.

## Structure
- Shared package holds:
  - state enum (IDLE, COUNT, LO, HI, CSUM, RUN, ERROR);
  - `INSTR_W`=9 and `ADDR_W`=8 defaults;
  - the HI-byte data bit index constant.
- One sub-module: `imem_array` — 2^ADDR_W × INSTR_W, one synchronous write port, one asynchronous read port, no reset.
- FSM, checksum, pointer and counters live in `imem_loader`.

## Test plan
- Reset, then idle with `rx_valid`=1 → `rx_ready`=0, `cpu_run`=0, `words_loaded`=0 for 10 cycles.
- `load_start`, stream 02, 34, 01, 7F, 00, CSUM=02^34^01^7F^00=48 → RUN one cycle after CSUM. mem[0]=0x134, mem[1]=0x07F. `instruction_address`=1 gives `instruction`=0x07F. `words_loaded`=2.
- Same stream with CSUM=49 → `load_error`=1, `cpu_run`=0. mem[0]=0x134 remains.
- N=00 with 256 pairs, pair k = (k, k&1) and correct CSUM → RUN, `words_loaded`=256. mem[255]=0x1FF.
- `load_start` pulsed mid-HI while `rx_valid`=1 → byte not accepted, state COUNT next cycle. A fresh 1-word load then reaches RUN with `words_loaded`=1.
- Reset asserted in RUN and in LO, with `rx_valid` toggling randomly → all outputs return to reset values on the next edge. Memory contents are unchanged.
